// File: rtl/lift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lift_pkg
// Description : Shared state encoding and direction constants for the lift.
// Revision    : 1.0 - initial release
// ============================================================================
package lift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } lift_state_e;

    localparam logic c_DIR_UP = 1'b1;
    localparam logic c_DIR_DN = 1'b0;

endpackage : lift_pkg
`default_nettype wire

// File: rtl/lift_req_reg.sv
`default_nettype none
// ============================================================================
// Module      : lift_req_reg
// Description : Latched per-floor call register with floor-relative summaries.
// Revision    : 1.0 - initial release
// ============================================================================
module lift_req_reg #(
    parameter int NUM_FLOORS = 8,
    localparam int FLW = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  set_block,
    input  logic                  clr_en,
    input  logic [FLW-1:0]        clr_idx,
    input  logic [FLW-1:0]        cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  hit
);

    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] w_block;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [NUM_FLOORS-1:0] w_pending_nx;
    logic                  w_above;
    logic                  w_below;

    // A clear in the same cycle as a set of the same floor wins: the floor is being served.
    always_comb begin
        w_block      = set_block ? (NUM_FLOORS'(1) << cur_floor) : '0;
        w_clr        = clr_en ? (NUM_FLOORS'(1) << clr_idx) : '0;
        w_pending_nx = (r_pending | (call_req & ~w_block)) & ~w_clr;
    end

    always_comb begin
        w_above = 1'b0;
        w_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(cur_floor)) w_above = w_above | r_pending[i];
            if (i < int'(cur_floor)) w_below = w_below | r_pending[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= w_pending_nx;
    end

    assign pending   = r_pending;
    assign any_above = w_above;
    assign any_below = w_below;
    assign hit       = r_pending[cur_floor];

endmodule : lift_req_reg
`default_nettype wire

// File: rtl/lift_ctrl_nfloor.sv
`default_nettype none
// ============================================================================
// Module      : lift_ctrl_nfloor
// Description : N-floor SCAN lift controller with travel and door timers.
// Revision    : 1.0 - initial release
// ============================================================================
module lift_ctrl_nfloor
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6,
    localparam int FLW = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [FLW-1:0]        cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrive
);

    localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TCW-1:0] c_T_LAST = TCW'(TRAVEL_CYCLES - 1);
    localparam logic [DCW-1:0] c_D_LAST = DCW'(DOOR_CYCLES - 1);
    localparam logic [FLW-1:0] c_TOP    = FLW'(NUM_FLOORS - 1);

    lift_state_e    r_state, w_state_nx;
    logic [FLW-1:0] r_floor, w_floor_nx, w_next_floor;
    logic           r_dir, w_dir_nx;
    logic [TCW-1:0] r_tcnt, w_tcnt_nx;
    logic [DCW-1:0] r_dcnt, w_dcnt_nx;
    logic           r_arrive, w_arrive_nx;
    logic           w_clr_en;
    logic [FLW-1:0] w_clr_idx;
    logic           w_any_above, w_any_below, w_hit, w_stop;
    logic [NUM_FLOORS-1:0] w_pending;

    lift_req_reg #(.NUM_FLOORS(NUM_FLOORS)) u_req (
        .clk       (clk),
        .rst_n     (rst_n),
        .call_req  (call_req),
        .set_block (r_state == ST_DOOR),
        .clr_en    (w_clr_en),
        .clr_idx   (w_clr_idx),
        .cur_floor (r_floor),
        .pending   (w_pending),
        .any_above (w_any_above),
        .any_below (w_any_below),
        .hit       (w_hit)
    );

    // Saturating step keeps the floor inside 0..top even on a malformed request set.
    always_comb begin
        if (r_dir == c_DIR_UP) w_next_floor = (r_floor == c_TOP) ? r_floor : r_floor + FLW'(1);
        else                   w_next_floor = (r_floor == '0)    ? r_floor : r_floor - FLW'(1);
        w_stop = w_pending[w_next_floor] | call_req[w_next_floor];
    end

    always_comb begin
        w_state_nx  = r_state;
        w_floor_nx  = r_floor;
        w_dir_nx    = r_dir;
        w_tcnt_nx   = r_tcnt;
        w_dcnt_nx   = r_dcnt;
        w_arrive_nx = 1'b0;
        w_clr_en    = 1'b0;
        w_clr_idx   = r_floor;
        if (start) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        w_state_nx = ST_DOOR;
                        w_dcnt_nx  = '0;
                        w_clr_en   = 1'b1;
                    end else if (|w_pending) begin
                        if (r_dir == c_DIR_UP) w_dir_nx = w_any_above ? c_DIR_UP : c_DIR_DN;
                        else                   w_dir_nx = w_any_below ? c_DIR_DN : c_DIR_UP;
                        w_state_nx = ST_MOVE;
                        w_tcnt_nx  = '0;
                    end
                end
                ST_MOVE: begin
                    if (r_tcnt == c_T_LAST) begin
                        w_tcnt_nx   = '0;
                        w_floor_nx  = w_next_floor;
                        w_arrive_nx = 1'b1;
                        if (w_stop) begin
                            w_state_nx = ST_DOOR;
                            w_dcnt_nx  = '0;
                            w_clr_en   = 1'b1;
                            w_clr_idx  = w_next_floor;
                        end
                    end else begin
                        w_tcnt_nx = r_tcnt + TCW'(1);
                    end
                end
                ST_DOOR: begin
                    if (call_req[r_floor])       w_dcnt_nx  = '0;
                    else if (r_dcnt == c_D_LAST) w_state_nx = ST_IDLE;
                    else                         w_dcnt_nx  = r_dcnt + DCW'(1);
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_floor  <= '0;
            r_dir    <= c_DIR_UP;
            r_tcnt   <= '0;
            r_dcnt   <= '0;
            r_arrive <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_floor  <= w_floor_nx;
            r_dir    <= w_dir_nx;
            r_tcnt   <= w_tcnt_nx;
            r_dcnt   <= w_dcnt_nx;
            r_arrive <= w_arrive_nx;
        end
    end

    assign cur_floor = r_floor;
    assign pending   = w_pending;
    assign dir_up    = r_dir;
    assign moving    = (r_state == ST_MOVE);
    assign door_open = (r_state == ST_DOOR);
    assign arrive    = r_arrive;

endmodule : lift_ctrl_nfloor
`default_nettype wire

// File: tb/tb_lift_ctrl_nfloor.sv
`default_nettype none
// ============================================================================
// Module      : tb_lift_ctrl_nfloor
// Description : Directed self-checking bench for the 8-floor lift controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lift_ctrl_nfloor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] call_req;
    logic [2:0] cur_floor;
    logic [7:0] pending;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic       arrive;

    int n_cmp;
    int n_err;

    lift_ctrl_nfloor #(
        .NUM_FLOORS    (8),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .call_req  (call_req),
        .cur_floor (cur_floor),
        .pending   (pending),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .arrive    (arrive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse a call for one cycle; returns just after the edge that latched it.
    task automatic pulse(input logic [7:0] req);
        call_req = req;
        step(1);
        call_req = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #1;
        step(1);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        call_req = '0;
        step(2);
        rst_n = 1'b1;
        step(1);

        // Reset with calls pending
        pulse(8'h0A);
        chk("pend_before_rst", pending, 8'h0A);
        rst_n = 1'b0;
        #1;
        chk("rst_pending", pending, 0);
        chk("rst_floor", cur_floor, 0);
        chk("rst_door", door_open, 0);
        chk("rst_dir", dir_up, 1);
        chk("rst_moving", moving, 0);
        step(1);
        rst_n = 1'b1;
        start = 1'b1;

        // Idle at 0, call floor 5
        pulse(8'h20);
        chk("c5_pending", pending, 8'h20);
        chk("c5_idle", moving, 0);
        step(1);
        chk("c5_move", moving, 1);
        for (int k = 1; k <= 5; k++) begin
            step(3);
            chk("c5_no_arrive", arrive, 0);
            step(1);
            chk("c5_floor", cur_floor, k);
            chk("c5_arrive", arrive, 1);
        end
        chk("c5_door", door_open, 1);
        chk("c5_clr", pending, 0);
        step(5);
        chk("c5_door_hold", door_open, 1);
        step(1);
        chk("c5_door_close", door_open, 0);
        chk("c5_idle_end", moving, 0);

        // From 0 up to 6, calls at 1 and 4 injected at floor 3
        do_reset();
        pulse(8'h40);
        step(1);
        step(12);
        chk("s3_at3", cur_floor, 3);
        pulse(8'h12);
        chk("s3_pending", pending, 8'h52);
        step(3);
        chk("s3_stop4", cur_floor, 4);
        chk("s3_door4", door_open, 1);
        chk("s3_pend4", pending, 8'h42);
        step(6);
        chk("s3_idle4", door_open, 0);
        step(1);
        chk("s3_move_up", moving, 1);
        chk("s3_dir_up", dir_up, 1);
        step(8);
        chk("s3_stop6", cur_floor, 6);
        chk("s3_door6", door_open, 1);
        chk("s3_pend6", pending, 8'h02);
        step(7);
        chk("s3_rev_move", moving, 1);
        chk("s3_rev_dir", dir_up, 0);
        step(20);
        chk("s3_stop1", cur_floor, 1);
        chk("s3_door1", door_open, 1);
        chk("s3_pend1", pending, 0);
        step(6);

        // Door extension at floor 2
        pulse(8'h04);
        step(1);
        chk("dx_dir_flip", dir_up, 1);
        step(4);
        chk("dx_at2", cur_floor, 2);
        chk("dx_open", door_open, 1);
        step(5);
        pulse(8'h04);
        chk("dx_still_open", door_open, 1);
        chk("dx_no_pend", pending, 0);
        step(5);
        chk("dx_hold", door_open, 1);
        chk("dx_hold_pend", pending, 0);
        step(1);
        chk("dx_close", door_open, 0);

        // Freeze mid-MOVE at floor 2 heading to 5
        pulse(8'h20);
        step(1);
        step(2);
        start = 1'b0;
        call_req = 8'h80;
        for (int k = 0; k < 10; k++) begin
            step(1);
            call_req = '0;
            chk("fz_arrive", arrive, 0);
        end
        chk("fz_floor", cur_floor, 2);
        chk("fz_moving", moving, 1);
        chk("fz_pending", pending, 8'hA0);
        start = 1'b1;
        step(1);
        chk("fz_resume_floor", cur_floor, 2);
        step(1);
        chk("fz_resume_arrive", cur_floor, 3);
        chk("fz_resume_pulse", arrive, 1);
        step(4);
        chk("fz_at4", cur_floor, 4);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("mr_floor", cur_floor, 0);
        chk("mr_moving", moving, 0);
        chk("mr_pending", pending, 0);
        step(1);
        rst_n = 1'b1;

        // Boundaries: top floor and ground
        pulse(8'h80);
        step(29);
        chk("bd_top", cur_floor, 7);
        chk("bd_top_door", door_open, 1);
        step(15);
        chk("bd_top_hold", cur_floor, 7);
        chk("bd_top_idle", moving, 0);
        pulse(8'h01);
        step(29);
        chk("bd_gnd", cur_floor, 0);
        chk("bd_gnd_dir", dir_up, 0);
        step(15);
        chk("bd_gnd_hold", cur_floor, 0);
        chk("bd_gnd_idle", moving, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_lift_ctrl_nfloor
`default_nettype wire
